// File: rtl/sb_issue_ctrl.sv
// Scoreboard issue/commit controller: allocates transaction IDs in a ring,
// records writebacks out of order and retires entries strictly in program order.
module sb_issue_ctrl #(
    parameter int NR_ENTRIES = 4,
    parameter int NR_WB      = 2,
    localparam int TID_W     = $clog2(NR_ENTRIES)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [3:0]                      issue_fu_i,
    input  logic [4:0]                      issue_rd_i,
    input  logic [4:0]                      issue_rs1_i,
    input  logic [4:0]                      issue_rs2_i,
    output logic [TID_W-1:0]                issue_trans_id_o,
    input  logic [NR_WB-1:0]                wb_valid_i,
    input  logic [NR_WB-1:0][TID_W-1:0]     wb_trans_id_i,
    input  logic [NR_WB-1:0][63:0]          wb_result_i,
    input  logic [NR_WB-1:0]                wb_ex_valid_i,
    input  logic [NR_WB-1:0][63:0]          wb_ex_cause_i,
    output logic                            commit_valid_o,
    input  logic                            commit_ack_i,
    output logic [TID_W-1:0]                commit_trans_id_o,
    output logic [3:0]                      commit_fu_o,
    output logic [4:0]                      commit_rd_o,
    output logic [63:0]                     commit_result_o,
    output logic                            commit_ex_valid_o,
    output logic [63:0]                     commit_ex_cause_o
);

    logic [NR_ENTRIES-1:0] occupied_r;
    logic [NR_ENTRIES-1:0] done_r;
    logic [NR_ENTRIES-1:0] ex_valid_r;
    logic [3:0]            fu_r       [NR_ENTRIES];
    logic [4:0]            rd_r       [NR_ENTRIES];
    logic [63:0]           result_r   [NR_ENTRIES];
    logic [63:0]           ex_cause_r [NR_ENTRIES];
    logic [TID_W-1:0]      issue_ptr_r;
    logic [TID_W-1:0]      commit_ptr_r;
    logic [TID_W:0]        count_r;

    logic                  full_s;
    logic                  raw_hazard_s;
    logic                  issue_fire_s;
    logic                  commit_valid_s;
    logic                  commit_fire_s;
    logic [NR_ENTRIES-1:0] wb_hit_s;
    logic [NR_ENTRIES-1:0] wb_ex_s;
    logic [63:0]           wb_res_s   [NR_ENTRIES];
    logic [63:0]           wb_cause_s [NR_ENTRIES];

    // RAW hazard against every in-flight destination; x0 never blocks.
    always_comb begin
        raw_hazard_s = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            raw_hazard_s = raw_hazard_s | (occupied_r[i] && (rd_r[i] != 5'd0) &&
                           ((rd_r[i] == issue_rs1_i) || (rd_r[i] == issue_rs2_i)));
        end
    end

    assign full_s           = (count_r == (TID_W+1)'(NR_ENTRIES));
    assign issue_ready_o    = !full_s && !raw_hazard_s && !flush_i;
    assign issue_fire_s     = issue_valid_i && issue_ready_o;
    assign issue_trans_id_o = issue_ptr_r;
    assign commit_valid_s   = occupied_r[commit_ptr_r] && done_r[commit_ptr_r];
    assign commit_fire_s    = commit_valid_s && commit_ack_i;

    // Per-entry writeback select; ports scanned high to low so port 0 wins ties.
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            wb_hit_s[i]   = 1'b0;
            wb_ex_s[i]    = 1'b0;
            wb_res_s[i]   = 64'd0;
            wb_cause_s[i] = 64'd0;
            for (int k = NR_WB - 1; k >= 0; k--) begin
                wb_hit_s[i]   = (wb_valid_i[k] && (wb_trans_id_i[k] == TID_W'(i))) ? 1'b1 : wb_hit_s[i];
                wb_ex_s[i]    = (wb_valid_i[k] && (wb_trans_id_i[k] == TID_W'(i))) ? wb_ex_valid_i[k] : wb_ex_s[i];
                wb_res_s[i]   = (wb_valid_i[k] && (wb_trans_id_i[k] == TID_W'(i))) ? wb_result_i[k] : wb_res_s[i];
                wb_cause_s[i] = (wb_valid_i[k] && (wb_trans_id_i[k] == TID_W'(i))) ? wb_ex_cause_i[k] : wb_cause_s[i];
            end
        end
    end

    // Head entry presented to commit; fields forced to zero while not valid.
    always_comb begin
        commit_valid_o = commit_valid_s;
        if (commit_valid_s) begin
            commit_trans_id_o = commit_ptr_r;
            commit_fu_o       = fu_r[commit_ptr_r];
            commit_rd_o       = rd_r[commit_ptr_r];
            commit_result_o   = result_r[commit_ptr_r];
            commit_ex_valid_o = ex_valid_r[commit_ptr_r];
            commit_ex_cause_o = ex_cause_r[commit_ptr_r];
        end else begin
            commit_trans_id_o = {TID_W{1'b0}};
            commit_fu_o       = 4'd0;
            commit_rd_o       = 5'd0;
            commit_result_o   = 64'd0;
            commit_ex_valid_o = 1'b0;
            commit_ex_cause_o = 64'd0;
        end
    end

    // Ring state: issue, writeback, commit; flush discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occupied_r   <= {NR_ENTRIES{1'b0}};
            done_r       <= {NR_ENTRIES{1'b0}};
            ex_valid_r   <= {NR_ENTRIES{1'b0}};
            issue_ptr_r  <= {TID_W{1'b0}};
            commit_ptr_r <= {TID_W{1'b0}};
            count_r      <= {(TID_W+1){1'b0}};
            for (int i = 0; i < NR_ENTRIES; i++) begin
                fu_r[i]       <= 4'd0;
                rd_r[i]       <= 5'd0;
                result_r[i]   <= 64'd0;
                ex_cause_r[i] <= 64'd0;
            end
        end else if (flush_i) begin
            occupied_r   <= {NR_ENTRIES{1'b0}};
            done_r       <= {NR_ENTRIES{1'b0}};
            issue_ptr_r  <= {TID_W{1'b0}};
            commit_ptr_r <= {TID_W{1'b0}};
            count_r      <= {(TID_W+1){1'b0}};
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (wb_hit_s[i] && occupied_r[i] && !done_r[i]) begin
                    done_r[i]     <= 1'b1;
                    ex_valid_r[i] <= wb_ex_s[i];
                    result_r[i]   <= wb_res_s[i];
                    ex_cause_r[i] <= wb_cause_s[i];
                end else begin
                    done_r[i] <= done_r[i];
                end
            end
            // Commit only touches a done entry and issue only a free one, so
            // neither can collide with an accepted writeback.
            if (commit_fire_s) begin
                occupied_r[commit_ptr_r] <= 1'b0;
                done_r[commit_ptr_r]     <= 1'b0;
                commit_ptr_r             <= commit_ptr_r + TID_W'(1);
            end else begin
                commit_ptr_r <= commit_ptr_r;
            end
            if (issue_fire_s) begin
                occupied_r[issue_ptr_r] <= 1'b1;
                done_r[issue_ptr_r]     <= 1'b0;
                ex_valid_r[issue_ptr_r] <= 1'b0;
                fu_r[issue_ptr_r]       <= issue_fu_i;
                rd_r[issue_ptr_r]       <= issue_rd_i;
                issue_ptr_r             <= issue_ptr_r + TID_W'(1);
            end else begin
                issue_ptr_r <= issue_ptr_r;
            end
            count_r <= count_r + {{TID_W{1'b0}}, issue_fire_s} - {{TID_W{1'b0}}, commit_fire_s};
        end
    end

endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Bench for sb_issue_ctrl: directed scenarios plus random traffic against an
// in-order program queue model; a separate monitor checks every commit.
module tb_sb_issue_ctrl;
    localparam int NR = 4;

    logic             clk_i = 1'b0;
    logic             rst_i, flush_i, issue_valid_i, issue_ready_o, commit_valid_o, commit_ack_i;
    logic [3:0]       issue_fu_i, commit_fu_o;
    logic [4:0]       issue_rd_i, issue_rs1_i, issue_rs2_i, commit_rd_o;
    logic [1:0]       issue_trans_id_o, commit_trans_id_o;
    logic [1:0]       wb_valid_i, wb_ex_valid_i;
    logic [1:0][1:0]  wb_trans_id_i;
    logic [1:0][63:0] wb_result_i, wb_ex_cause_i;
    logic             commit_ex_valid_o;
    logic [63:0]      commit_result_o, commit_ex_cause_o;

    sb_issue_ctrl #(.NR_ENTRIES(NR), .NR_WB(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_fu_i(issue_fu_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_result_i(wb_result_i),
        .wb_ex_valid_i(wb_ex_valid_i), .wb_ex_cause_i(wb_ex_cause_i),
        .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
        .commit_trans_id_o(commit_trans_id_o), .commit_fu_o(commit_fu_o),
        .commit_rd_o(commit_rd_o), .commit_result_o(commit_result_o),
        .commit_ex_valid_o(commit_ex_valid_o), .commit_ex_cause_o(commit_ex_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int seq; int tid; logic [4:0] rd; bit done; } ent_t;
    ent_t mq[$];
    int exp_q[$];
    int tid_a[int];
    logic [3:0]  fu_a[int];
    logic [4:0]  rd_a[int];
    logic [63:0] res_a[int];
    logic [63:0] cause_a[int];
    logic        exv_a[int];
    int next_tid = 0, next_seq = 0, model_commits = 0, mon_commits = 0;
    int n_tests = 0, n_fail = 0;

    logic st_iv, st_ack, st_fl;
    logic [3:0] st_fu;
    logic [4:0] st_rd, st_rs1, st_rs2;
    logic [1:0] st_wv, st_exv;
    logic [1:0] st_tid [2];
    logic [63:0] st_res [2];
    logic [63:0] st_cause [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_stim();
        st_iv = 1'b0; st_ack = 1'b0; st_fl = 1'b0; st_fu = 4'd0;
        st_rd = 5'd0; st_rs1 = 5'd0; st_rs2 = 5'd0; st_wv = 2'b00; st_exv = 2'b00;
        for (int k = 0; k < 2; k++) begin st_tid[k] = 2'd0; st_res[k] = 64'd0; st_cause[k] = 64'd0; end
    endtask

    // One clock: apply stimulus, check issue/commit visibility, advance the model.
    task automatic cycle();
        bit hz, exp_ready, exp_cv;
        issue_valid_i = st_iv; issue_fu_i = st_fu; issue_rd_i = st_rd;
        issue_rs1_i = st_rs1; issue_rs2_i = st_rs2; commit_ack_i = st_ack; flush_i = st_fl;
        wb_valid_i = st_wv; wb_ex_valid_i = st_exv;
        for (int k = 0; k < 2; k++) begin
            wb_trans_id_i[k] = st_tid[k]; wb_result_i[k] = st_res[k]; wb_ex_cause_i[k] = st_cause[k];
        end
        hz = 1'b0;
        foreach (mq[i]) if (mq[i].rd != 5'd0 && (mq[i].rd == st_rs1 || mq[i].rd == st_rs2)) hz = 1'b1;
        exp_ready = (mq.size() < NR) && !hz && !st_fl;
        exp_cv = (mq.size() > 0) && mq[0].done;
        @(negedge clk_i);
        chk("issue_ready", {63'd0, issue_ready_o}, {63'd0, exp_ready});
        chk("issue_trans_id", {62'd0, issue_trans_id_o}, 64'(next_tid));
        chk("commit_valid", {63'd0, commit_valid_o}, {63'd0, exp_cv});
        if (!exp_cv)
            chk("commit_idle_zero", commit_result_o | commit_ex_cause_o |
                {55'd0, commit_ex_valid_o, commit_fu_o, commit_rd_o[2:0] | {1'b0, commit_trans_id_o}}
                | {59'd0, commit_rd_o}, 64'd0);
        if (st_fl) begin
            mq.delete(); exp_q.delete(); next_tid = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (st_wv[k]) begin
                    foreach (mq[i]) begin
                        if (mq[i].tid == int'(st_tid[k]) && !mq[i].done) begin
                            mq[i].done = 1'b1;
                            res_a[mq[i].seq] = st_res[k];
                            exv_a[mq[i].seq] = st_exv[k];
                            cause_a[mq[i].seq] = st_cause[k];
                        end
                    end
                end
            end
            if (exp_cv && st_ack) begin
                void'(mq.pop_front());
                model_commits++;
            end
            if (st_iv && exp_ready) begin
                ent_t e;
                e.seq = next_seq; e.tid = next_tid; e.rd = st_rd; e.done = 1'b0;
                mq.push_back(e);
                tid_a[next_seq] = next_tid; fu_a[next_seq] = st_fu; rd_a[next_seq] = st_rd;
                exp_q.push_back(next_seq);
                next_seq++;
                next_tid = (next_tid + 1) % NR;
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        clr_stim(); st_iv = 1'b1; st_fu = rd[3:0] ^ 4'h5; st_rd = rd; st_rs1 = rs1; st_rs2 = rs2;
        cycle();
    endtask

    task automatic do_wb(input int port, input logic [1:0] tid, input logic [63:0] res, input logic ack);
        clr_stim(); st_ack = ack; st_wv[port] = 1'b1; st_tid[port] = tid; st_res[port] = res;
        cycle();
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", {63'd0, issue_ready_o}, 64'd1);
        chk("rst_tid", {62'd0, issue_trans_id_o}, 64'd0);
        chk("rst_commit_valid", {63'd0, commit_valid_o}, 64'd0);
        chk("rst_commit_result", commit_result_o | commit_ex_cause_o, 64'd0);
    endtask

    // Commit monitor: every consumed head must match the next program-order record.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && commit_valid_o && commit_ack_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_unexpected: got tid %0d expected no commit", commit_trans_id_o);
                end else begin
                    int s;
                    s = exp_q.pop_front();
                    mon_commits++;
                    n_tests--;
                    chk("commit_tid", {62'd0, commit_trans_id_o}, 64'(tid_a[s]));
                    chk("commit_fu", {60'd0, commit_fu_o}, {60'd0, fu_a[s]});
                    chk("commit_rd", {59'd0, commit_rd_o}, {59'd0, rd_a[s]});
                    chk("commit_result", commit_result_o, res_a.exists(s) ? res_a[s] : 64'hDEAD);
                    chk("commit_ex_valid", {63'd0, commit_ex_valid_o}, {63'd0, exv_a.exists(s) ? exv_a[s] : 1'b1});
                    chk("commit_ex_cause", commit_ex_cause_o, cause_a.exists(s) ? cause_a[s] : 64'hDEAD);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_stim();
        rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; commit_ack_i = 1'b0;
        issue_fu_i = 4'd0; issue_rd_i = 5'd0; issue_rs1_i = 5'd0; issue_rs2_i = 5'd0;
        wb_valid_i = 2'b00; wb_ex_valid_i = 2'b00; wb_trans_id_i = '{default: 2'd0};
        wb_result_i = '{default: 64'd0}; wb_ex_cause_i = '{default: 64'd0};
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_state();
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Fill the ring, then offer a fifth instruction that must be held.
        for (int r = 1; r <= 4; r++) do_issue(5'(r), 5'd0, 5'd0);
        do_issue(5'd9, 5'd0, 5'd0);
        // Out-of-order writeback, in-order commit.
        do_wb(0, 2'd2, 64'hA2, 1'b1);
        do_wb(0, 2'd0, 64'hA0, 1'b1);
        do_wb(0, 2'd1, 64'hA1, 1'b1);
        clr_stim(); st_ack = 1'b1; st_wv[1] = 1'b1; st_tid[1] = 2'd3; st_res[1] = 64'hA3;
        st_exv[1] = 1'b1; st_cause[1] = 64'h2; cycle();
        clr_stim(); st_ack = 1'b1; repeat (3) cycle();
        // Both ports hit the same ID in one cycle.
        do_issue(5'd6, 5'd0, 5'd0);
        do_issue(5'd7, 5'd0, 5'd0);
        clr_stim(); st_ack = 1'b1; st_wv = 2'b11; st_tid[0] = 2'd1; st_tid[1] = 2'd1;
        st_res[0] = 64'h11; st_res[1] = 64'h22; cycle();
        do_wb(1, 2'd0, 64'h10, 1'b1);
        clr_stim(); st_ack = 1'b1; repeat (3) cycle();
        // RAW hazard on rd=5, x0 never blocks, hazard clears after commit.
        do_issue(5'd5, 5'd0, 5'd0);
        do_issue(5'd8, 5'd5, 5'd0);
        do_issue(5'd0, 5'd0, 5'd0);
        do_issue(5'd8, 5'd0, 5'd0);
        do_issue(5'd9, 5'd3, 5'd5);
        do_wb(0, 2'd2, 64'h55, 1'b0);
        do_wb(0, 2'd3, 64'h66, 1'b1);
        do_wb(0, 2'd0, 64'h77, 1'b1);
        do_issue(5'd9, 5'd5, 5'd0);
        clr_stim(); st_ack = 1'b1; repeat (4) cycle();
        // Flush with three occupied entries and concurrent issue/writeback/ack.
        for (int r = 10; r < 13; r++) do_issue(5'(r), 5'd0, 5'd0);
        do_wb(0, 2'(next_tid - 3 + NR), 64'hF0, 1'b0);
        clr_stim(); st_fl = 1'b1; st_iv = 1'b1; st_rd = 5'd14; st_ack = 1'b1;
        st_wv = 2'b01; st_tid[0] = 2'(next_tid - 2 + NR); st_res[0] = 64'hF1; cycle();
        clr_stim(); cycle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            clr_stim();
            st_iv = ($urandom_range(0, 3) != 0);
            st_fu = 4'($urandom_range(0, 15));
            st_rd = 5'($urandom_range(0, 7));
            st_rs1 = 5'($urandom_range(0, 9));
            st_rs2 = 5'($urandom_range(0, 9));
            st_ack = ($urandom_range(0, 3) != 0);
            st_fl = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 2; k++) begin
                st_wv[k] = ($urandom_range(0, 1) == 1);
                if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                    st_tid[k] = 2'(mq[$urandom_range(0, mq.size() - 1)].tid);
                else
                    st_tid[k] = 2'($urandom_range(0, 3));
                st_res[k] = {$urandom, $urandom};
                st_exv[k] = ($urandom_range(0, 7) == 0);
                st_cause[k] = {32'd0, $urandom};
            end
            cycle();
        end

        // Reset in the middle of traffic.
        clr_stim(); st_iv = 1'b1; st_rd = 5'd3; cycle();
        rst_i = 1'b1; clr_stim();
        issue_valid_i = 1'b0; commit_ack_i = 1'b0; wb_valid_i = 2'b00; flush_i = 1'b0;
        @(posedge clk_i); #1;
        mq.delete(); exp_q.delete(); next_tid = 0;
        @(negedge clk_i);
        chk_reset_state();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 2) do_issue(5'(c + 1), 5'd0, 5'd0);
            else do_wb(0, 2'(c - 2), 64'(c), 1'b1);
        end
        clr_stim(); st_ack = 1'b1; repeat (3) cycle();

        chk("commit_count", 64'(mon_commits), 64'(model_commits));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(mq.size()));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_issue_ctrl.md
# sb_issue_ctrl

In-order issue/commit controller for the scoreboard. Allocates transaction IDs to instructions issued from ID, records writeback results from the functional-unit writeback ports, detects RAW hazards on source registers, and presents completed instructions to the commit stage strictly in program order. Sits between ID/issue and commit, owning the scoreboard entry ring.

## Interface
- NR_ENTRIES, 4: scoreboard depth (power of two, matches NR_SB_ENTRIES); ID width TID_W = $clog2(NR_ENTRIES)
- NR_WB, 2: number of writeback ports (matches NR_WB_PORTS)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (mispredict/exception)
- issue_valid_i  in  1  instruction offered for issue
- issue_ready_o  out  1  entry free and no RAW hazard
- issue_fu_i  in  4  fu_t of instruction
- issue_rd_i / issue_rs1_i / issue_rs2_i  in  5 each  register addresses
- issue_trans_id_o  out  TID_W  ID assigned if issued this cycle (= issue pointer)
- wb_valid_i  in  NR_WB  per-port writeback strobe
- wb_trans_id_i  in  NR_WB×TID_W  target entry
- wb_result_i  in  NR_WB×64  result
- wb_ex_valid_i  in  NR_WB  exception flag; wb_ex_cause_i  in  NR_WB×64  cause
- commit_valid_o  out  1  head entry occupied and done
- commit_ack_i  in  1  commit stage consumes head
- commit_trans_id_o  out  TID_W; commit_fu_o  out  4; commit_rd_o  out  5; commit_result_o  out  64; commit_ex_valid_o  out  1; commit_ex_cause_o  out  64  head entry fields

## Operation
- State: per entry occupied, done, fu, rd, result, ex_valid, ex_cause; issue_ptr, commit_ptr (TID_W, wrap modulo NR_ENTRIES); count (TID_W+1 bits, 0..NR_ENTRIES).
- full = (count == NR_ENTRIES). raw_hazard = any occupied entry with rd == issue_rs1_i or rd == issue_rs2_i, rd != 0; register x0 never hazards. Entries already done still hazard (no forwarding) until committed.
- issue_ready_o = !full & !raw_hazard & !flush_i. Issue fires on issue_valid_i & issue_ready_o: entry[issue_ptr] ← occupied=1, done=0, ex_valid=0, fu/rd captured; issue_ptr++, count++.
- Writeback port k fires on wb_valid_i[k] with entry[wb_trans_id_i[k]] occupied & !done: sets done, stores result, ex_valid, ex_cause. Writeback to unoccupied or already-done entry ignored. Two ports hitting same ID in one cycle: lowest port index wins.
- commit_valid_o = entry[commit_ptr].occupied & done; commit_* outputs driven from entry[commit_ptr] (zero when !commit_valid_o). Commit fires on commit_valid_o & commit_ack_i: entry cleared (occupied=0, done=0), commit_ptr++, count--. commit_ack_i without commit_valid_o ignored.
- Issue and commit in same cycle: count unchanged; both pointers advance.
- flush_i: all occupied/done cleared, issue_ptr=commit_ptr=0, count=0; overrides issue, writeback and commit in that cycle (commit not counted).

## Timing
- Reset (rst_i high at edge): all entries cleared, pointers and count 0. Outputs after reset: issue_ready_o = 1 (unless hazard impossible, since no entries), issue_trans_id_o = 0, commit_valid_o = 0, all commit_* = 0. Reset mid-operation behaves as flush plus result/cause registers zeroed.
- issue_ready_o and issue_trans_id_o combinational from state and issue_rs*; no combinational path from wb_* or commit_ack_i to any output.
- Latency: issue at cycle N → earliest writeback N+1 → commit_valid_o at N+2. Writeback visible to commit next cycle only (no bypass).
- Slot freed by commit in cycle N usable for issue at N+1 (ready computed from registered count).
- Hazard on rd clears the cycle after that entry commits.

## Test plan
- Reset then issue 4 instrs rd=1..4, rs=0 → trans_id 0,1,2,3; issue_ready_o=0 after 4th (full); 5th held.
- Out-of-order writeback: wb IDs 2,0,1 on port 0 in successive cycles, commit_ack_i=1 → commit_valid_o only after ID 0 done; commits in order 0,1,2 with matching results (e.g. 0xA0,0xA1,0xA2).
- Dual writeback same cycle: port0 ID1 result 0x11, port1 ID1 result 0x22 → committed result 0x11; port1 ID3 alone with ex_valid=1 cause 0x2 → commit_ex_valid_o=1, cause 0x2.
- RAW: entry rd=5 pending, issue rs1=5 → issue_ready_o=0; rs2=0 with rd=0 entry → ready=1; after rd=5 commits, ready=1 next cycle.
- Full ring wrap: continuous issue+commit for 10 instrs → trans_id sequence 0,1,2,3,0,1,… count stays ≤4, no loss.
- flush_i with 3 entries occupied plus concurrent issue/wb/ack → next cycle count=0, commit_valid_o=0, issue_trans_id_o=0, no commit emitted.
